rip_decode_q: RTL and testbench

Queued, handshaked decode stage for the rip-cpu RV32 pipeline, sitting between fetch and execute. A parametrised-depth instruction queue decouples fetch from decode, and valid/ready handshakes replace the single-stall interface. Decoded fields are registered, with per-instruction PC tracking and a flush input for redirects. The RV32M multiply/divide decode is optional, and unrecognised encodings are flagged as illegal instead of being silently decoded to a bubble.

---
 rtl/rip_decode_q.sv | 277 +++++++++++++++++++++++++++
 tb/tb_rip_decode_q.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/rip_decode_q.sv
// rip_decode_q: queued valid/ready decode stage for the rip-cpu RV32 pipeline.
// A DEPTH-entry {pc, inst} queue feeds a registered decoder with flush support.
// Optional RV32M decode is enabled by defining RIP_M_EXT_EN.
package rip_decode_q_pkg;
  typedef struct packed {
    logic LUI, AUIPC, JAL, JALR, BEQ, BNE, BLT, BGE, BLTU, BGEU;
    logic LB, LH, LW, LBU, LHU, SB, SH, SW;
    logic ADDI, SLTI, SLTIU, XORI, ORI, ANDI, SLLI, SRLI, SRAI;
    logic ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND;
    logic FENCE, ECALL, EBREAK, CSRRW, CSRRS, CSRRC, CSRRWI, CSRRSI, CSRRCI;
    logic ACCESS_MEM, UPDATE_REG, UPDATE_CSR, UPDATE_PC;
  } inst_t;
endpackage

module rip_decode_q
  import rip_decode_q_pkg::*;
#(
  parameter int DEPTH    = 4,
  parameter int PC_WIDTH = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [31:0]               in_inst,
  input  logic [PC_WIDTH-1:0]       in_pc,
  input  logic                      flush,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [PC_WIDTH-1:0]       out_pc,
  output logic [4:0]                if_rs1_num,
  output logic [4:0]                if_rs2_num,
  output logic [4:0]                rs1_num,
  output logic [4:0]                rs2_num,
  output logic [4:0]                rd_num,
  output logic [11:0]               csr_num,
  output logic [4:0]                csr_zimm,
  output logic [31:0]               imm,
  output inst_t                     inst,
  output logic [7:0]                m_op,
  output logic                      illegal,
  output logic [$clog2(DEPTH):0]    count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef struct packed {
    inst_t       inst;
    logic [7:0]  m_op;
    logic [4:0]  rs1, rs2, rd;
    logic [11:0] csr;
    logic [4:0]  zimm;
    logic [31:0] imm;
    logic        illegal;
  } dec_t;

  // Full decode of one word; an unrecognised word yields only the illegal flag.
  function automatic dec_t decode(input logic [31:0] w);
    dec_t       d;
    logic [2:0] f3;
    logic [6:0] f7;
    logic       ok, fr, fi, fs, fb, fu, fj, fc, fz, sh;
    d  = '0;
    f3 = w[14:12];
    f7 = w[31:25];
    ok = 1'b1;
    fr = 1'b0; fi = 1'b0; fs = 1'b0; fb = 1'b0;
    fu = 1'b0; fj = 1'b0; fc = 1'b0; fz = 1'b0; sh = 1'b0;
    case (w[6:0])
      7'b0110111: begin d.inst.LUI = 1'b1; fu = 1'b1; end
      7'b0010111: begin d.inst.AUIPC = 1'b1; fu = 1'b1; end
      7'b1101111: begin d.inst.JAL = 1'b1; fj = 1'b1; end
      7'b1100111: begin d.inst.JALR = (f3 == 3'd0); ok = (f3 == 3'd0); fi = 1'b1; end
      7'b1100011: begin
        fb = 1'b1;
        case (f3)
          3'd0: d.inst.BEQ  = 1'b1;
          3'd1: d.inst.BNE  = 1'b1;
          3'd4: d.inst.BLT  = 1'b1;
          3'd5: d.inst.BGE  = 1'b1;
          3'd6: d.inst.BLTU = 1'b1;
          3'd7: d.inst.BGEU = 1'b1;
          default: ok = 1'b0;
        endcase
      end
      7'b0000011: begin
        fi = 1'b1;
        case (f3)
          3'd0: d.inst.LB  = 1'b1;
          3'd1: d.inst.LH  = 1'b1;
          3'd2: d.inst.LW  = 1'b1;
          3'd4: d.inst.LBU = 1'b1;
          3'd5: d.inst.LHU = 1'b1;
          default: ok = 1'b0;
        endcase
      end
      7'b0100011: begin
        fs = 1'b1;
        case (f3)
          3'd0: d.inst.SB = 1'b1;
          3'd1: d.inst.SH = 1'b1;
          3'd2: d.inst.SW = 1'b1;
          default: ok = 1'b0;
        endcase
      end
      7'b0010011: begin
        fi = 1'b1;
        case (f3)
          3'd0: d.inst.ADDI  = 1'b1;
          3'd2: d.inst.SLTI  = 1'b1;
          3'd3: d.inst.SLTIU = 1'b1;
          3'd4: d.inst.XORI  = 1'b1;
          3'd6: d.inst.ORI   = 1'b1;
          3'd7: d.inst.ANDI  = 1'b1;
          3'd1: begin d.inst.SLLI = (f7 == 7'h00); ok = (f7 == 7'h00); sh = 1'b1; end
          default: begin
            d.inst.SRLI = (f7 == 7'h00);
            d.inst.SRAI = (f7 == 7'h20);
            ok = (f7 == 7'h00) || (f7 == 7'h20);
            sh = 1'b1;
          end
        endcase
      end
      7'b0110011: begin
        fr = 1'b1;
        case (f7)
          7'h00: begin
            case (f3)
              3'd0: d.inst.ADD  = 1'b1;
              3'd1: d.inst.SLL  = 1'b1;
              3'd2: d.inst.SLT  = 1'b1;
              3'd3: d.inst.SLTU = 1'b1;
              3'd4: d.inst.XOR  = 1'b1;
              3'd5: d.inst.SRL  = 1'b1;
              3'd6: d.inst.OR   = 1'b1;
              default: d.inst.AND = 1'b1;
            endcase
          end
          7'h20: begin
            d.inst.SUB = (f3 == 3'd0);
            d.inst.SRA = (f3 == 3'd5);
            ok = (f3 == 3'd0) || (f3 == 3'd5);
          end
`ifdef RIP_M_EXT_EN
          7'h01: d.m_op[f3] = 1'b1;
`endif
          default: ok = 1'b0;
        endcase
      end
      7'b0001111: begin d.inst.FENCE = (f3 == 3'd0); ok = (f3 == 3'd0); end
      7'b1110011: begin
        case (f3)
          3'd0: begin
            d.inst.ECALL  = (w == 32'h0000_0073);
            d.inst.EBREAK = (w == 32'h0010_0073);
            ok = d.inst.ECALL | d.inst.EBREAK;
          end
          3'd1: begin d.inst.CSRRW  = 1'b1; fc = 1'b1; end
          3'd2: begin d.inst.CSRRS  = 1'b1; fc = 1'b1; end
          3'd3: begin d.inst.CSRRC  = 1'b1; fc = 1'b1; end
          3'd5: begin d.inst.CSRRWI = 1'b1; fz = 1'b1; end
          3'd6: begin d.inst.CSRRSI = 1'b1; fz = 1'b1; end
          3'd7: begin d.inst.CSRRCI = 1'b1; fz = 1'b1; end
          default: ok = 1'b0;
        endcase
      end
      default: ok = 1'b0;
    endcase
    d.rd   = (fr | fi | fu | fj | fc | fz) ? w[11:7]  : 5'd0;
    d.rs1  = (fr | fi | fs | fb | fc)      ? w[19:15] : 5'd0;
    d.rs2  = (fr | fs | fb)                ? w[24:20] : 5'd0;
    d.csr  = (fc | fz)                     ? w[31:20] : 12'd0;
    d.zimm = fz                            ? w[19:15] : 5'd0;
    if (sh)      d.imm = {27'd0, w[24:20]};
    else if (fi) d.imm = {{20{w[31]}}, w[31:20]};
    else if (fs) d.imm = {{20{w[31]}}, w[31:25], w[11:7]};
    else if (fb) d.imm = {{20{w[31]}}, w[7], w[30:25], w[11:8], 1'b0};
    else if (fu) d.imm = {w[31:12], 12'd0};
    else if (fj) d.imm = {{12{w[31]}}, w[19:12], w[20], w[30:21], 1'b0};
    d.inst.ACCESS_MEM = d.inst.LB | d.inst.LH | d.inst.LW | d.inst.LBU | d.inst.LHU |
                        d.inst.SB | d.inst.SH | d.inst.SW;
    d.inst.UPDATE_REG = (d.rd != 5'd0);
    d.inst.UPDATE_CSR = fc | fz;
    d.inst.UPDATE_PC  = d.inst.JAL | d.inst.JALR | fb | d.inst.ECALL | d.inst.EBREAK;
    if (!ok) begin
      d         = '0;
      d.illegal = 1'b1;
    end
    return d;
  endfunction

  logic [PC_WIDTH-1:0] pc_mem   [DEPTH];
  logic [31:0]         inst_mem [DEPTH];
  logic [AW-1:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]       count_q, count_d;
  logic                out_valid_q, out_valid_d;
  logic [PC_WIDTH-1:0] out_pc_q, out_pc_d;
  dec_t                dec_q, dec_d, head_dec;
  logic                empty, push, pop, adv;

  // Handshakes and the combinational view of the queue head.
  always_comb begin
    empty      = (count_q == '0);
    in_ready   = (count_q != CW'(DEPTH));
    push       = in_valid & in_ready;
    adv        = ~out_valid_q | out_ready;
    pop        = adv & ~empty;
    head_dec   = decode(inst_mem[rd_ptr_q]);
    if_rs1_num = empty ? 5'd0 : head_dec.rs1;
    if_rs2_num = empty ? 5'd0 : head_dec.rs2;
  end

  // Next state: queue bookkeeping, output advance, flush overrides both.
  always_comb begin
    wr_ptr_d    = wr_ptr_q + AW'(push);
    rd_ptr_d    = rd_ptr_q + AW'(pop);
    count_d     = count_q + CW'(push) - CW'(pop);
    out_valid_d = out_valid_q;
    out_pc_d    = out_pc_q;
    dec_d       = dec_q;
    if (adv) begin
      out_valid_d = ~empty;
      out_pc_d    = empty ? '0 : pc_mem[rd_ptr_q];
      dec_d       = empty ? '0 : head_dec;
    end
    if (flush) begin
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      count_d     = '0;
      out_valid_d = 1'b0;
      out_pc_d    = '0;
      dec_d       = '0;
    end
  end

  // Queue storage; a word offered during flush is dropped.
  always_ff @(posedge clk) begin
    if (push && !flush) begin
      pc_mem[wr_ptr_q]   <= in_pc;
      inst_mem[wr_ptr_q] <= in_inst;
    end
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      out_valid_q <= 1'b0;
      out_pc_q    <= '0;
      dec_q       <= '0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      out_valid_q <= out_valid_d;
      out_pc_q    <= out_pc_d;
      dec_q       <= dec_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_pc    = out_pc_q;
  assign rs1_num   = dec_q.rs1;
  assign rs2_num   = dec_q.rs2;
  assign rd_num    = dec_q.rd;
  assign csr_num   = dec_q.csr;
  assign csr_zimm  = dec_q.zimm;
  assign imm       = dec_q.imm;
  assign inst      = dec_q.inst;
  assign m_op      = dec_q.m_op;
  assign illegal   = dec_q.illegal;
  assign count     = count_q;

endmodule

// File: tb/tb_rip_decode_q.sv
// Bench for rip_decode_q: instructions are built from chosen fields (encoder),
// expected decode comes from those fields; a queue model tracks occupancy/order.
module tb_rip_decode_q;
  import rip_decode_q_pkg::*;

  localparam int DEPTH = 4;
  localparam int PW    = 32;

  logic                 clk = 1'b0;
  logic                 rst, in_valid, in_ready, flush, out_valid, out_ready, illegal;
  logic [31:0]          in_inst, imm;
  logic [PW-1:0]        in_pc, out_pc;
  logic [4:0]           if_rs1_num, if_rs2_num, rs1_num, rs2_num, rd_num, csr_zimm;
  logic [11:0]          csr_num;
  logic [7:0]           m_op;
  inst_t                inst;
  logic [$clog2(DEPTH):0] count;

  always #5 clk = ~clk;

  rip_decode_q #(.DEPTH(DEPTH), .PC_WIDTH(PW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_inst(in_inst), .in_pc(in_pc), .flush(flush), .out_valid(out_valid),
    .out_ready(out_ready), .out_pc(out_pc), .if_rs1_num(if_rs1_num),
    .if_rs2_num(if_rs2_num), .rs1_num(rs1_num), .rs2_num(rs2_num),
    .rd_num(rd_num), .csr_num(csr_num), .csr_zimm(csr_zimm), .imm(imm),
    .inst(inst), .m_op(m_op), .illegal(illegal), .count(count)
  );

  typedef struct packed {
    logic [31:0]   word;
    logic [PW-1:0] pc;
    inst_t         inst;
    logic [7:0]    m_op;
    logic [4:0]    rs1, rs2, rd;
    logic [11:0]   csr;
    logic [4:0]    zimm;
    logic [31:0]   imm;
    logic          illegal;
  } exp_t;

  int      checks = 0;
  int      errors = 0;
  int      n_acc  = 0;
  int      a0;
  bit      chk_en = 0;
  exp_t    q[$];
  exp_t    oe;
  logic    ov;
  exp_t    nx;
  logic [PW-1:0] pc_ctr = 32'h200;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Encode an instruction of kind k from fields; return its expected decode.
  function automatic exp_t gen(input int k, input logic [4:0] rd, input logic [4:0] rs1,
                               input logic [4:0] rs2, input logic [31:0] r, input logic [PW-1:0] pc);
    exp_t        e;
    logic [11:0] i12;
    logic [12:0] b13;
    logic [20:0] j21;
    e = '0; e.pc = pc;
    i12 = r[11:0]; b13 = {r[12:1], 1'b0}; j21 = {r[20:1], 1'b0};
    case (k)
      0: begin e.word = {i12, rs1, 3'd0, rd, 7'h13}; e.inst.ADDI = 1; e.rd = rd; e.rs1 = rs1;
               e.imm = {{20{i12[11]}}, i12}; end
      1: begin e.word = {7'h20, r[4:0], rs1, 3'd5, rd, 7'h13}; e.inst.SRAI = 1; e.rd = rd;
               e.rs1 = rs1; e.imm = {27'd0, r[4:0]}; end
      2: begin e.word = {i12, rs1, 3'd2, rd, 7'h03}; e.inst.LW = 1; e.rd = rd; e.rs1 = rs1;
               e.imm = {{20{i12[11]}}, i12}; e.inst.ACCESS_MEM = 1; end
      3: begin e.word = {i12[11:5], rs2, rs1, 3'd2, i12[4:0], 7'h23}; e.inst.SW = 1; e.rs1 = rs1;
               e.rs2 = rs2; e.imm = {{20{i12[11]}}, i12}; e.inst.ACCESS_MEM = 1; end
      4: begin e.word = {b13[12], b13[10:5], rs2, rs1, 3'd0, b13[4:1], b13[11], 7'h63};
               e.inst.BEQ = 1; e.rs1 = rs1; e.rs2 = rs2; e.imm = {{19{b13[12]}}, b13};
               e.inst.UPDATE_PC = 1; end
      5: begin e.word = {r[31:12], rd, 7'h37}; e.inst.LUI = 1; e.rd = rd; e.imm = {r[31:12], 12'd0}; end
      6: begin e.word = {j21[20], j21[10:1], j21[11], j21[19:12], rd, 7'h6f}; e.inst.JAL = 1;
               e.rd = rd; e.imm = {{11{j21[20]}}, j21}; e.inst.UPDATE_PC = 1; end
      7: begin e.word = {7'h20, rs2, rs1, 3'd0, rd, 7'h33}; e.inst.SUB = 1; e.rd = rd;
               e.rs1 = rs1; e.rs2 = rs2; end
      8: begin e.word = {i12, rs1, 3'd1, rd, 7'h73}; e.inst.CSRRW = 1; e.rd = rd; e.rs1 = rs1;
               e.csr = i12; e.inst.UPDATE_CSR = 1; end
      9: begin e.word = {i12, rs1, 3'd6, rd, 7'h73}; e.inst.CSRRSI = 1; e.rd = rd; e.zimm = rs1;
               e.csr = i12; e.inst.UPDATE_CSR = 1; end
      10: begin e.word = 32'h0000_0073; e.inst.ECALL = 1; e.inst.UPDATE_PC = 1; end
      11: begin
        e.word = {7'h01, rs2, rs1, r[2:0], rd, 7'h33};
`ifdef RIP_M_EXT_EN
        e.m_op[r[2:0]] = 1'b1; e.rd = rd; e.rs1 = rs1; e.rs2 = rs2;
`else
        e.illegal = 1;
`endif
      end
      default: begin e.word = {r[31:7], 7'h00}; e.illegal = 1; end
    endcase
    if (!e.illegal) e.inst.UPDATE_REG = (e.rd != 5'd0);
    return e;
  endfunction

  function automatic exp_t rnd(input logic [PW-1:0] pc);
    return gen(int'($urandom_range(0, 12)), 5'($urandom), 5'($urandom), 5'($urandom), $urandom, pc);
  endfunction

  task automatic drive(input exp_t e);
    nx = e; in_valid = 1; in_inst = e.word; in_pc = e.pc;
    pc_ctr = pc_ctr + 4;
  endtask

  task automatic check_outputs();
    logic [4:0] h1, h2;
    h1 = '0; h2 = '0;
    if (q.size() != 0) begin h1 = q[0].rs1; h2 = q[0].rs2; end
    chk("count", 64'(count), 64'(q.size()));
    chk("in_ready", 64'(in_ready), 64'(q.size() < DEPTH));
    chk("if_rs1", 64'(if_rs1_num), 64'(h1));
    chk("if_rs2", 64'(if_rs2_num), 64'(h2));
    chk("out_valid", 64'(out_valid), 64'(ov));
    chk("out_pc", 64'(out_pc), 64'(oe.pc));
    chk("inst", 64'(inst), 64'(oe.inst));
    chk("imm", 64'(imm), 64'(oe.imm));
    chk("rd", 64'(rd_num), 64'(oe.rd));
    chk("rs1", 64'(rs1_num), 64'(oe.rs1));
    chk("rs2", 64'(rs2_num), 64'(oe.rs2));
    chk("csr", 64'(csr_num), 64'(oe.csr));
    chk("zimm", 64'(csr_zimm), 64'(oe.zimm));
    chk("m_op", 64'(m_op), 64'(oe.m_op));
    chk("illegal", 64'(illegal), 64'(oe.illegal));
  endtask

  // One clock: check current outputs, then advance the reference model.
  task automatic tick();
    logic acc, adv;
    @(negedge clk);
    if (chk_en) check_outputs();
    acc = in_valid && !rst && !flush && (q.size() < DEPTH);
    @(posedge clk);
    if (rst || flush) begin
      q.delete(); ov = 0; oe = '0;
    end else begin
      adv = !ov || out_ready;
      if (adv) begin
        if (q.size() != 0) begin oe = q.pop_front(); ov = 1; end
        else begin ov = 0; oe = '0; end
      end
      if (acc) begin q.push_back(nx); n_acc++; end
    end
    #1;
  endtask

  task automatic idle(input int n);
    in_valid = 0; out_ready = 1;
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    rst = 1; in_valid = 0; in_inst = '0; in_pc = '0; flush = 0; out_ready = 0;
    ov = 0; oe = '0; nx = '0;
    tick(); tick();
    rst = 0; chk_en = 1;
    tick();
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_valid", 64'(out_valid), 64'd0);

    // ADDI x1,x0,5 at 0x100
    out_ready = 1;
    drive(gen(0, 5'd1, 5'd0, 5'd0, 32'd5, 32'h100));
    tick(); in_valid = 0; tick();
    chk("addi_valid", 64'(out_valid), 64'd1);
    chk("addi_op", 64'(inst.ADDI), 64'd1);
    chk("addi_rd", 64'(rd_num), 64'd1);
    chk("addi_rs1", 64'(rs1_num), 64'd0);
    chk("addi_imm", 64'(imm), 64'd5);
    chk("addi_upd", 64'(inst.UPDATE_REG), 64'd1);
    chk("addi_pc", 64'(out_pc), 64'h100);

    // SRAI x2,x3,4
    drive(gen(1, 5'd2, 5'd3, 5'd0, 32'd4, 32'h104));
    tick(); in_valid = 0;
    chk("srai_if_rs1", 64'(if_rs1_num), 64'd3);
    tick();
    chk("srai_op", 64'(inst.SRAI), 64'd1);
    chk("srai_imm", 64'(imm), 64'd4);
    chk("srai_rs1", 64'(rs1_num), 64'd3);
    chk("srai_rd", 64'(rd_num), 64'd2);

    // Capacity: DEPTH+1 words with out_ready low, then ordered drain
    idle(2);
    out_ready = 0; a0 = n_acc;
    for (int i = 0; i < 8; i++) begin drive(rnd(pc_ctr)); tick(); end
    in_valid = 0;
    chk("cap_accepted", 64'(n_acc - a0), 64'd5);
    chk("cap_count", 64'(count), 64'd4);
    chk("cap_in_ready", 64'(in_ready), 64'd0);
    chk("cap_out_valid", 64'(out_valid), 64'd1);
    idle(7);

    // MUL x1,x1,x1
    drive(gen(11, 5'd1, 5'd1, 5'd1, 32'd0, 32'h300));
    tick(); in_valid = 0; tick();
    chk("mul_valid", 64'(out_valid), 64'd1);
`ifdef RIP_M_EXT_EN
    chk("mul_mop", 64'(m_op), 64'h01);
    chk("mul_illegal", 64'(illegal), 64'd0);
`else
    chk("mul_illegal", 64'(illegal), 64'd1);
    chk("mul_mop", 64'(m_op), 64'd0);
    chk("mul_upd", 64'(inst.UPDATE_REG), 64'd0);
`endif
    chk("mul_pc", 64'(out_pc), 64'h300);

    // Flush with 3 queued, output valid, and a push in the same cycle
    idle(2);
    out_ready = 0;
    for (int i = 0; i < 4; i++) begin drive(rnd(pc_ctr)); tick(); end
    in_valid = 0;
    chk("fl_pre_count", 64'(count), 64'd3);
    chk("fl_pre_valid", 64'(out_valid), 64'd1);
    drive(rnd(pc_ctr)); flush = 1;
    tick();
    flush = 0; in_valid = 0;
    chk("fl_count", 64'(count), 64'd0);
    chk("fl_valid", 64'(out_valid), 64'd0);
    chk("fl_imm", 64'(imm), 64'd0);
    idle(3);

    // Reset with 2 queued
    out_ready = 0;
    for (int i = 0; i < 3; i++) begin drive(rnd(pc_ctr)); tick(); end
    in_valid = 0;
    chk("rs_pre_count", 64'(count), 64'd2);
    rst = 1; tick(); rst = 0;
    chk("rs_valid", 64'(out_valid), 64'd0);
    chk("rs_count", 64'(count), 64'd0);
    chk("rs_in_ready", 64'(in_ready), 64'd1);
    chk("rs_imm", 64'(imm), 64'd0);
    chk("rs_rd", 64'(rd_num), 64'd0);
    idle(3);

    // Random traffic against the model
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) != 0) drive(rnd(pc_ctr)); else in_valid = 0;
      out_ready = ($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 31) == 0);
      rst       = ($urandom_range(0, 63) == 0);
      tick();
    end
    rst = 0; flush = 0;
    idle(8);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
